fp_mult_arbiter: RTL
====================

FP_MULT_ARBITER -- requirements
Module: fp_mult_arbiter

Interface
REQ-001 Parameter MULT_LAT, default 1, is the number of clk cycles from operand drive to a valid multiplier result; legal range 1..4.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req0_valid, req1_valid  input  1 each  requester n presents an operand pair.
REQ-006 req0_ready, req1_ready  output  1 each  operand pair of requester n accepted this cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  32 each  IEEE-754 single operands.
REQ-008 rsp0_valid, rsp1_valid  output  1 each  result for requester n is held.
REQ-009 rsp0_ready, rsp1_ready  input  1 each  requester n consumes its result.
REQ-010 rsp_z  output  32  product; rsp_status  output  8  multiplier status flags; shared by both response channels.
REQ-011 mult_a, mult_b  output  32 each  operands to the shared fp_mult instance.
REQ-012 mult_z  input  32; mult_status  input  8  result from the shared fp_mult instance.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-014 IDLE: no valid request -> stay IDLE, both reqN_ready = 0.
REQ-015 IDLE: one valid request -> grant it; reqN_ready = 1 combinationally in that cycle; latch operands into op_a/op_b and owner; go to WAIT with cnt = MULT_LAT.
REQ-016 IDLE: both valid -> grant the requester not served last (last_grant register); never assert both ready in the same cycle.
REQ-017 mult_a/mult_b SHALL be driven from op_a/op_b registers only and held constant from the transition into WAIT until the transition out of RESP.
REQ-018 WAIT: cnt decrements each cycle; in the cycle cnt == 1, capture mult_z/mult_status into rsp_z/rsp_status and go to RESP.
REQ-019 RESP: rsp<owner>_valid = 1, the other rsp valid = 0; rsp_z/rsp_status stable until handshake.
REQ-020 RESP with rsp<owner>_ready = 1 -> go to IDLE, last_grant <= owner; rsp_ready of the non-owner is ignored.
REQ-021 Latency, acceptance to rsp_valid: MULT_LAT + 1 cycles; minimum issue interval MULT_LAT + 2 cycles.
REQ-022 reqN_ready SHALL be 0 in WAIT and RESP; requests held valid there wait without loss.
REQ-023 Fairness: with both requesters continuously valid, grants SHALL strictly alternate.
REQ-024 No arithmetic on operand data; result bits pass through unmodified.

Reset
REQ-025 On rst: state = IDLE, op_a = op_b = 0, rsp_z = 0, rsp_status = 0, cnt = 0, owner = 0, last_grant = 1 (requester 0 wins the first tie); all valid/ready outputs 0; mult_a = mult_b = 0.
REQ-026 rst asserted in WAIT or RESP SHALL abort the operation; the pending result is discarded and no rsp_valid is issued for it.
REQ-027 rst has priority over every handshake in the same cycle.

Verification
REQ-028 Single op, MULT_LAT=1: req0 a=0x40400000, b=0x40000000 -> req0_ready 1 cycle, rsp0_valid 2 cycles later, rsp_z=0x40C00000, rsp_status=0x00.
REQ-029 Tie after reset: req0 = 1.5*1.5 (0x3FC00000), req1 = 3.0*2.0, both valid -> req0 served first (rsp_z=0x40100000), then req1 (0x40C00000); 4 back-to-back ops per requester alternate 0,1,0,1...
REQ-030 Backpressure: rsp1_ready held 0 for 5 cycles in RESP -> rsp1_valid and rsp_z stay stable, req0/req1_ready stay 0, no new grant until rsp1_ready=1.
REQ-031 Reset mid-op: rst pulsed in WAIT with MULT_LAT=3 -> all outputs 0 next cycle, no rsp_valid for the aborted op; the next request completes normally.
REQ-032 Latency sweep MULT_LAT=1..4: acceptance to rsp_valid = MULT_LAT+1 cycles; mult_a/mult_b are constant throughout WAIT and RESP.
REQ-033 Status passthrough: a=0x7F800000 (+inf), b=0x00000000 -> rsp_z/rsp_status equal the mult_z/mult_status sampled in the last WAIT cycle, bit-exact.

Source files
------------

// File: rtl/fp_mult_arbiter.sv
// Two-requester round-robin front end for one shared floating-point multiplier.
// Operands are held steady for the whole operation; the result is captured and held until consumed.
`timescale 1ns/1ps
module fp_mult_arbiter #(
   parameter int MULT_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   input  logic        rsp0_ready,
   input  logic        rsp1_ready,
   output logic [31:0] rsp_z,
   output logic [7:0]  rsp_status,
   output logic [31:0] mult_a,
   output logic [31:0] mult_b,
   input  logic [31:0] mult_z,
   input  logic [7:0]  mult_status
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [2:0] LAT = 3'(MULT_LAT);

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_op_a;
   logic [31:0] r_op_b;
   logic [31:0] r_rsp_z;
   logic [7:0]  r_rsp_status;
   logic [2:0]  r_cnt;
   logic        r_owner;
   logic        r_last_grant;

   logic        w_grant;
   logic        w_grant_id;
   logic        w_capture;
   logic        w_rsp_fire;

   always_comb begin
      w_state_next = r_state;
      w_grant      = 1'b0;
      w_grant_id   = 1'b0;
      w_capture    = 1'b0;
      w_rsp_fire   = 1'b0;
      case (r_state)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               w_grant      = 1'b1;
               // On a tie the requester that was not served last wins.
               w_grant_id   = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
               w_state_next = WAIT;
            end
         end
         WAIT: begin
            if (r_cnt == 3'd1) begin
               w_capture    = 1'b1;
               w_state_next = RESP;
            end
         end
         RESP: begin
            if (r_owner ? rsp1_ready : rsp0_ready) begin
               w_rsp_fire   = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_op_a       <= 32'd0;
         r_op_b       <= 32'd0;
         r_rsp_z      <= 32'd0;
         r_rsp_status <= 8'd0;
         r_cnt        <= 3'd0;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         r_state <= w_state_next;
         if (w_grant) begin
            r_op_a  <= w_grant_id ? req1_a : req0_a;
            r_op_b  <= w_grant_id ? req1_b : req0_b;
            r_owner <= w_grant_id;
            r_cnt   <= LAT;
         end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - 3'd1;
         end
         if (w_capture) begin
            r_rsp_z      <= mult_z;
            r_rsp_status <= mult_status;
         end
         if (w_rsp_fire) begin
            r_last_grant <= r_owner;
         end
      end
   end

   // Handshake outputs are masked while reset is high so reset beats any transfer.
   assign req0_ready = !rst && w_grant && !w_grant_id;
   assign req1_ready = !rst && w_grant && w_grant_id;
   assign rsp0_valid = !rst && (r_state == RESP) && !r_owner;
   assign rsp1_valid = !rst && (r_state == RESP) && r_owner;
   assign rsp_z      = r_rsp_z;
   assign rsp_status = r_rsp_status;
   assign mult_a     = r_op_a;
   assign mult_b     = r_op_b;

endmodule
